// File: rtl/wav_stream_checker.sv
// Stream drain/checker: deterministic tready backpressure, incrementing-sequence check, saturating counters.
// Optional stall timeout is built only when WAV_STR_CHECKER_TIMEOUT_EN is defined.
module wav_stream_checker #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 16,
    parameter int unsigned TO = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctl_run,
    input  logic          ctl_clr,
    input  logic [7:0]    ctl_bp,
    input  logic          tvalid,
    output logic          tready,
    input  logic [DW-1:0] tdata,
    output logic          sts_end,
    output logic          sts_err,
    output logic          sts_to,
    output logic [CW-1:0] sts_cnt,
    output logic [CW-1:0] sts_err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DW-1:0] LAST    = '1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state_q, state_d;
    logic [2:0]    ptr_q;
    logic [DW-1:0] exp_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] err_cnt_q;
    logic          end_q;
    logic          err_q;
    logic          trn_c;
    logic          last_c;
    logic          mism_c;
    logic          to_hit_c;

    // tready depends only on registered state, the pattern pointer and the live mask
    assign tready = (state_q == RUN) && ctl_bp[ptr_q];
    assign trn_c  = tvalid && tready;
    assign last_c = trn_c && (tdata == LAST);
    assign mism_c = trn_c && (tdata != exp_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ctl_run) state_d = RUN;
            end
            RUN: begin
                if (last_c)        state_d = DONE;
                else if (!ctl_run) state_d = IDLE;
                else if (to_hit_c) state_d = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (ctl_clr) state_d = IDLE;
    end

    // ctl_clr behaves as a synchronous clear with priority over everything but rst
    always_ff @(posedge clk) begin
        if (rst || ctl_clr) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            exp_q     <= '0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
            end_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == RUN) ptr_q <= ptr_q + 3'd1;
            if (trn_c) begin
                // resync to the received word so a single drop costs one error
                exp_q <= tdata + DW'(1);
                if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CW'(1);
                if (mism_c) begin
                    err_q <= 1'b1;
                    if (err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + CW'(1);
                end
                if (last_c) end_q <= 1'b1;
            end
        end
    end

`ifdef WAV_STR_CHECKER_TIMEOUT_EN
    logic [CW-1:0] stall_q;
    logic          to_q;

    // stall_q holds the number of stall cycles already seen; this cycle is number stall_q+1
    assign to_hit_c = (state_q == RUN) && !trn_c && (stall_q == CW'(TO - 1));

    always_ff @(posedge clk) begin
        if (rst || ctl_clr) begin
            stall_q <= '0;
            to_q    <= 1'b0;
        end else begin
            if ((state_q == RUN) && (state_d == RUN) && !trn_c) stall_q <= stall_q + CW'(1);
            else                                                stall_q <= '0;
            if ((state_q == RUN) && (state_d == DONE) && !last_c) to_q <= 1'b1;
        end
    end

    assign sts_to = to_q;
`else
    assign to_hit_c = 1'b0;
    // TO only matters when the stall counter is built
    assign sts_to   = 1'b0 & (TO == 0);
`endif

    assign sts_end     = end_q;
    assign sts_err     = err_q;
    assign sts_cnt     = cnt_q;
    assign sts_err_cnt = err_cnt_q;

endmodule

// File: doc/wav_stream_checker.md
Name: wav_stream_checker

Overview:
- Stream drain and checker for the valid/ready counter stream produced by the stream source.
- Applies a programmable, deterministic backpressure pattern on tready.
- Checks that each accepted tdata continues an incrementing sequence, and counts transfers and mismatches.
- Sits at the drain end of the stream interface in test/example designs, replacing the always-ready drain when data integrity and backpressure must be exercised.

Parameters:
- DW, 8, stream data width.
- CW, 16, width of the transfer and error counters.
- TO, 64, stall timeout in clock cycles. Used only when WAV_STR_CHECKER_TIMEOUT_EN is defined; legal range 1..2**CW-1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- ctl_run  input  1  enables draining while high.
- ctl_clr  input  1  one-cycle pulse: clears counters and status, returns to IDLE.
- ctl_bp  input  8  backpressure mask; bit i enables tready in pattern slot i.
- tvalid  input  1  stream valid.
- tready  output  1  stream ready.
- tdata  input  DW  stream data.
- sts_end  output  1  sticky; last word (all ones) received.
- sts_err  output  1  sticky; at least one sequence mismatch.
- sts_to  output  1  sticky; stall timeout hit (0 when feature compiled out).
- sts_cnt  output  CW  accepted transfer count, saturating.
- sts_err_cnt  output  CW  mismatch count, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, tready=0, sts_end=0, sts_err=0, sts_to=0, sts_cnt=0, sts_err_cnt=0, expected value exp=0, pattern pointer ptr=0.
- Transfer: trn = tvalid & tready in the same cycle.
- tready timing: tready is a combinational function of registered state, ptr and ctl_bp only. There is no path from tvalid to tready.
- Pattern pointer: ptr is a 3-bit counter that increments every cycle in RUN and wraps 7->0. It holds in IDLE and DONE.
- Pattern timing: ctl_bp is sampled live each cycle; a change takes effect in the same cycle.
- State IDLE: tready=0. ctl_run=1 -> RUN next cycle.
- State RUN: tready = ctl_bp[ptr]. Transitions:
  - ctl_run=0 -> IDLE. Counters, exp and ptr are kept.
  - trn with tdata == all ones -> DONE; sts_end=1 on the next cycle.
- State DONE: tready=0. Holds until ctl_clr. ctl_run is ignored.
- Data check on each trn:
  - Mismatch if tdata != exp. A mismatch sets sts_err and increments sts_err_cnt.
  - exp <= tdata+1, modulo 2**DW. The checker resyncs to the received data, so one dropped word gives exactly one error.
  - sts_cnt increments on every trn.
- Counters: sts_cnt and sts_err_cnt saturate at 2**CW-1 and never wrap.
- ctl_clr: valid in any state and has priority over ctl_run and trn in the same cycle. Next cycle: IDLE, all counters, sticky flags, exp and ptr at reset values. A trn coincident with ctl_clr is not counted or checked.
- Final word: all ones is checked like any other word. A mismatching final word still ends the run and also flags an error.
- Reset mid-transfer: takes effect at the clock edge regardless of tvalid/trn. tready is 0 in the following cycle.

Optional Feature:
- Macro: WAV_STR_CHECKER_TIMEOUT_EN.
- Defined:
  - A stall counter counts consecutive RUN cycles without trn. It clears on trn, on leaving RUN, and on ctl_clr.
  - Stalls caused by tready=0 from the mask count as well.
  - When the counter reaches TO: sts_to=1 (sticky) and the state goes to DONE the next cycle; sts_end stays 0.
- Not defined: no stall counter is built; sts_to is tied to 0; the TO parameter is unused.

Test Plan:
- Reset, then ctl_run=1, ctl_bp=8'hFF, source sends 0..255 back-to-back -> tready=1 every RUN cycle; sts_cnt=256, sts_err=0, sts_err_cnt=0; sts_end=1 one cycle after the 255 transfer; tready=0 afterward.
- ctl_bp=8'b0101_0101, tvalid held high -> tready toggles every cycle starting with slot 0 high; 256 words accepted in 512 RUN cycles; sts_err=0.
- Stream 0,1,2,4,5,...,255 (3 skipped) -> sts_err_cnt=1, sts_err=1, sts_cnt=255, sts_end=1.
- Mid-stream ctl_run=0 for 10 cycles after word 100, then 1 -> tready=0 while low; no errors; counting resumes at 101; final sts_cnt=256.
- ctl_clr pulse while in DONE, with tvalid=1 in the same cycle -> next cycle IDLE, all sts_* = 0, that word is not counted. Reset asserted mid-stream gives the same all-zero outputs.
- With WAV_STR_CHECKER_TIMEOUT_EN, TO=16, tvalid=0 in RUN -> sts_to=1 and DONE after 16 stall cycles, sts_end=0. Without the macro -> stays in RUN, sts_to=0.
